// File: rtl/fp32_pkg.sv
// fp32_pkg: constants and class encoding shared by the fp32 datapath blocks.
// Contents: IEEE-754 single-precision field widths, exponent bias, the all-ones
// exponent code, the operand class enum and a classifier helper.
package fp32_pkg;

  localparam int         FP32_BIAS    = 127;
  localparam int         FP32_EXP_W   = 8;
  localparam int         FP32_MAN_W   = 23;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // zero or subnormal (flushed)
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Classify an operand from its exponent and stored mantissa fields.
  function automatic fp_class_e fp32_classify(input logic [FP32_EXP_W-1:0] exp_v,
                                              input logic [FP32_MAN_W-1:0] man_v);
    fp_class_e cls;
    if (exp_v == 8'h00) begin
      cls = CLS_ZERO;
    end else if (exp_v == FP32_EXP_MAX) begin
      if (man_v == 23'd0) begin
        cls = CLS_INF;
      end else begin
        cls = CLS_NAN;
      end
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: combinational field split of an fp32 word.
// Ports:
//   i_din   fp32 operand
//   o_sign  sign bit
//   o_exp   biased exponent
//   o_mant  24-bit significand with the hidden bit set
//   o_cls   operand class (zero/subnormal, normal, inf, nan)
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]           i_din,
  output logic                  o_sign,
  output logic [FP32_EXP_W-1:0] o_exp,
  output logic [FP32_MAN_W:0]   o_mant,
  output fp_class_e             o_cls
);

  logic [FP32_MAN_W-1:0] w_man;

  assign o_sign = i_din[31];
  assign o_exp  = i_din[30:23];
  assign w_man  = i_din[22:0];
  // The hidden bit is always set; consumers ignore o_mant unless o_cls is CLS_NORM.
  assign o_mant = {1'b1, w_man};
  assign o_cls  = fp32_classify(o_exp, w_man);

endmodule

// File: rtl/fp32_to_fix.sv
// fp32_to_fix: 3-stage fp32 -> signed fixed-point converter, one sample per clock.
// Parameters: OUT_W output width (8..32), FRAC_W fractional bits (0..OUT_W-1).
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   din, valid_in        fp32 input and qualifier
//   dout, valid_out      signed fixed-point result and qualifier
//   sat_flag             result clamped or input was inf/nan
module fp32_to_fix
  import fp32_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      din,
  input  logic             valid_in,
  output logic [OUT_W-1:0] dout,
  output logic             valid_out,
  output logic             sat_flag
);

  localparam int MAG_W = OUT_W + 1;
  localparam int EXT_W = MAG_W + 24;
  localparam logic signed [9:0] K_OVF = 10'(OUT_W);
  localparam logic signed [9:0] K_MIN = -10'sd1;
  // One half in the 24-fraction-bit extended format used for rounding.
  localparam logic [EXT_W-1:0] HALF        = {{(EXT_W-24){1'b0}}, 1'b1, 23'd0};
  localparam logic [MAG_W-1:0] MAG_MAX     = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MAG_NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN     = {1'b1, {(OUT_W-1){1'b0}}};

  logic                  w_sign;
  logic [FP32_EXP_W-1:0] w_exp;
  logic [FP32_MAN_W:0]   w_mant;
  fp_class_e             w_cls;
  logic [9:0]            w_k;

  fp32_unpack u_unpack (
    .i_din  (din),
    .o_sign (w_sign),
    .o_exp  (w_exp),
    .o_mant (w_mant),
    .o_cls  (w_cls)
  );

  // k = unbiased exponent plus the output fraction width (two's complement, 10 bits).
  assign w_k = {2'b00, w_exp} - 10'(FP32_BIAS) + 10'(FRAC_W);

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  fp_class_e             r_s1_cls;
  logic [FP32_MAN_W:0]   r_s1_mant;
  logic signed [9:0]     r_s1_k;

  // S1: register the unpacked operand and its scale.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cls   <= CLS_ZERO;
      r_s1_mant  <= 24'd0;
      r_s1_k     <= 10'sd0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_sign  <= w_sign;
      r_s1_cls   <= w_cls;
      r_s1_mant  <= w_mant;
      r_s1_k     <= $signed(w_k);
    end
  end

  logic [5:0]       w_shamt;
  logic [EXT_W-1:0] w_ext;
  logic [MAG_W-1:0] w_mag;
  logic             w_ovf;

  // Place M so bits [EXT_W-1:24] hold the integer magnitude and [23:0] its fraction;
  // only meaningful for -1 <= k < OUT_W, where the shift stays within 0..OUT_W.
  assign w_shamt = 6'(r_s1_k + 10'sd1);
  assign w_ext   = EXT_W'(r_s1_mant) << w_shamt;

  // S2 combinational: overflow screen, then shift and round half away from zero.
  always_comb begin
    w_mag = {MAG_W{1'b0}};
    w_ovf = 1'b0;
    if (r_s1_cls != CLS_NORM) begin
      w_mag = {MAG_W{1'b0}};
      w_ovf = 1'b0;
    end else if (r_s1_k >= K_OVF) begin
      // Magnitude >= 2^OUT_W: beyond any representable value of either sign.
      w_ovf = 1'b1;
    end else if (r_s1_k < K_MIN) begin
      // Magnitude < 0.5 LSB.
      w_mag = {MAG_W{1'b0}};
    end else begin
      w_mag = MAG_W'((w_ext + HALF) >> 6'd24);
    end
  end

  logic             r_s2_valid;
  logic             r_s2_sign;
  fp_class_e        r_s2_cls;
  logic [MAG_W-1:0] r_s2_mag;
  logic             r_s2_ovf;

  // S2: register rounded magnitude and overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_cls   <= CLS_ZERO;
      r_s2_mag   <= {MAG_W{1'b0}};
      r_s2_ovf   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_cls   <= r_s1_cls;
      r_s2_mag   <= w_mag;
      r_s2_ovf   <= w_ovf;
    end
  end

  logic [OUT_W-1:0] w_dout;
  logic             w_sat;

  // S3 combinational: apply sign, clamp to [MIN, MAX], map special classes.
  always_comb begin
    w_dout = {OUT_W{1'b0}};
    w_sat  = 1'b0;
    case (r_s2_cls)
      CLS_ZERO: begin
        w_dout = {OUT_W{1'b0}};
        w_sat  = 1'b0;
      end
      CLS_NAN: begin
        w_dout = {OUT_W{1'b0}};
        w_sat  = 1'b1;
      end
      CLS_INF: begin
        w_dout = r_s2_sign ? OUT_MIN : OUT_MAX;
        w_sat  = 1'b1;
      end
      CLS_NORM: begin
        if (r_s2_ovf) begin
          w_dout = r_s2_sign ? OUT_MIN : OUT_MAX;
          w_sat  = 1'b1;
        end else if (r_s2_sign) begin
          if (r_s2_mag > MAG_NEG_LIM) begin
            w_dout = OUT_MIN;
            w_sat  = 1'b1;
          end else begin
            // Exactly 2^(OUT_W-1) negates to MIN; a zero magnitude stays 0.
            w_dout = {OUT_W{1'b0}} - r_s2_mag[OUT_W-1:0];
            w_sat  = 1'b0;
          end
        end else begin
          if (r_s2_mag > MAG_MAX) begin
            w_dout = OUT_MAX;
            w_sat  = 1'b1;
          end else begin
            w_dout = r_s2_mag[OUT_W-1:0];
            w_sat  = 1'b0;
          end
        end
      end
      default: begin
        w_dout = {OUT_W{1'b0}};
        w_sat  = 1'b0;
      end
    endcase
  end

  // S3: output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      dout      <= {OUT_W{1'b0}};
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= r_s2_valid;
      dout      <= w_dout;
      sat_flag  <= w_sat;
    end
  end

endmodule

// File: tb/tb_fp32_to_fix.sv
// tb_fp32_to_fix: scoreboard bench for fp32_to_fix.
// Two instances: u_dut_int (OUT_W=16, FRAC_W=0) and u_dut_frac (OUT_W=16, FRAC_W=8).
module tb_fp32_to_fix;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] din_a, din_b;
  logic        valid_a, valid_b;
  logic [15:0] dout_a, dout_b;
  logic        vout_a, vout_b, sat_a, sat_b;

  always #5 clk = ~clk;

  fp32_to_fix #(.OUT_W(16), .FRAC_W(0)) u_dut_int (
    .clk(clk), .rstn(rstn), .din(din_a), .valid_in(valid_a),
    .dout(dout_a), .valid_out(vout_a), .sat_flag(sat_a)
  );

  fp32_to_fix #(.OUT_W(16), .FRAC_W(8)) u_dut_frac (
    .clk(clk), .rstn(rstn), .din(din_b), .valid_in(valid_b),
    .dout(dout_b), .valid_out(vout_b), .sat_flag(sat_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries: {din[31:0], dout[15:0], sat}
  logic [48:0] q_a[$];
  logic [48:0] q_b[$];

  localparam int NCLS = 19;
  localparam logic [48:0] CLS_TBL [NCLS] = '{
    {32'h3F000000, 16'h0001, 1'b0},  // 0.5 rounds up
    {32'h3EFFFFFF, 16'h0000, 1'b0},  // just below 0.5
    {32'h3FC00000, 16'h0002, 1'b0},  // 1.5
    {32'hBFC00000, 16'hFFFE, 1'b0},  // -1.5
    {32'h40200000, 16'h0003, 1'b0},  // 2.5
    {32'hBF000000, 16'hFFFF, 1'b0},  // -0.5 away from zero
    {32'hBE800000, 16'h0000, 1'b0},  // -0.25 -> plain 0
    {32'hC6000000, 16'hE000, 1'b0},  // -8192
    {32'h46FFFE00, 16'h7FFF, 1'b0},  // 32767
    {32'h47000000, 16'h7FFF, 1'b1},  // 32768
    {32'hC7000000, 16'h8000, 1'b0},  // -32768
    {32'hC7000100, 16'h8000, 1'b1},  // -32769
    {32'h4F800000, 16'h7FFF, 1'b1},  // 2^32
    {32'hCF800000, 16'h8000, 1'b1},  // -2^32
    {32'h7F800000, 16'h7FFF, 1'b1},  // +inf
    {32'hFF800000, 16'h8000, 1'b1},  // -inf
    {32'h7FC00000, 16'h0000, 1'b1},  // nan
    {32'h00400000, 16'h0000, 1'b0},  // subnormal
    {32'h80000000, 16'h0000, 1'b0}   // -0
  };

  localparam int NFRAC = 8;
  localparam logic [48:0] FRAC_TBL [NFRAC] = '{
    {32'h3F800000, 16'h0100, 1'b0},  // 1.0
    {32'h3B800000, 16'h0001, 1'b0},  // 2^-8
    {32'hBB000000, 16'hFFFF, 1'b0},  // -2^-9 tie away from zero
    {32'h3A800000, 16'h0000, 1'b0},  // 2^-10
    {32'h3F400000, 16'h00C0, 1'b0},  // 0.75
    {32'hC0000000, 16'hFE00, 1'b0},  // -2.0
    {32'h43000000, 16'h7FFF, 1'b1},  // 128.0 overflows
    {32'hC3000000, 16'h8000, 1'b0}   // -128.0 is exactly MIN
  };

  localparam int NSTR = 8;
  localparam logic [48:0] STR_TBL [NSTR] = '{
    {32'h3F800000, 16'h0001, 1'b0},
    {32'h40000000, 16'h0002, 1'b0},
    {32'h40400000, 16'h0003, 1'b0},
    {32'hBF800000, 16'hFFFF, 1'b0},
    {32'h42C80000, 16'h0064, 1'b0},
    {32'hC2C80000, 16'hFF9C, 1'b0},
    {32'h3F400000, 16'h0001, 1'b0},
    {32'h447A2000, 16'h03E9, 1'b0}   // 1000.5
  };

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({vout_a, dout_a, sat_a} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_int got v/d/s=%b/%h/%b exp 0/0000/0", vout_a, dout_a, sat_a);
    end
    n_vec++;
    if ({vout_b, dout_b, sat_b} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_frac got v/d/s=%b/%h/%b exp 0/0000/0", vout_b, dout_b, sat_b);
    end
    rstn = 1'b1;
  endtask

  task automatic test_class_vectors();
    logic [48:0] vec;
    logic [48:0] e;
    logic [2:0]  vh;
    vh = 3'b000;
    for (int i = 0; i < NCLS + 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (vout_a !== vh[2]) begin
        n_err++;
        $display("FAIL cls_valid cycle %0d got %b exp %b", i, vout_a, vh[2]);
      end
      if (vout_a === 1'b1) begin
        n_vec++;
        if (q_a.size() == 0) begin
          n_err++;
          $display("FAIL cls_extra cycle %0d got dout %h, exp no output", i, dout_a);
        end else begin
          e = q_a.pop_front();
          if ({dout_a, sat_a} !== e[16:0]) begin
            n_err++;
            $display("FAIL cls din=%h got %h/%b exp %h/%b", e[48:17], dout_a, sat_a, e[16:1], e[0]);
          end
        end
      end
      if (i < NCLS) begin
        vec = CLS_TBL[i];
        din_a = vec[48:17];
        valid_a = 1'b1;
        q_a.push_back(vec);
      end else begin
        din_a = 32'h0;
        valid_a = 1'b0;
      end
      vh = {vh[1:0], valid_a};
    end
    n_vec++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL cls_drain got %0d pending exp 0", q_a.size());
    end
  endtask

  task automatic test_frac();
    logic [48:0] vec;
    logic [48:0] e;
    logic [2:0]  vh;
    vh = 3'b000;
    for (int i = 0; i < NFRAC + 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (vout_b !== vh[2]) begin
        n_err++;
        $display("FAIL frac_valid cycle %0d got %b exp %b", i, vout_b, vh[2]);
      end
      if (vout_b === 1'b1) begin
        n_vec++;
        if (q_b.size() == 0) begin
          n_err++;
          $display("FAIL frac_extra cycle %0d got dout %h, exp no output", i, dout_b);
        end else begin
          e = q_b.pop_front();
          if ({dout_b, sat_b} !== e[16:0]) begin
            n_err++;
            $display("FAIL frac din=%h got %h/%b exp %h/%b", e[48:17], dout_b, sat_b, e[16:1], e[0]);
          end
        end
      end
      if (i < NFRAC) begin
        vec = FRAC_TBL[i];
        din_b = vec[48:17];
        valid_b = 1'b1;
        q_b.push_back(vec);
      end else begin
        din_b = 32'h0;
        valid_b = 1'b0;
      end
      vh = {vh[1:0], valid_b};
    end
    n_vec++;
    if (q_b.size() != 0) begin
      n_err++;
      $display("FAIL frac_drain got %0d pending exp 0", q_b.size());
    end
  endtask

  // 8 back-to-back samples, then 8 cycles of alternating valid with junk data in the gaps.
  task automatic test_back_to_back();
    logic [48:0] vec;
    logic [48:0] e;
    logic [2:0]  vh;
    logic        v;
    int          j;
    vh = 3'b000;
    j = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (vout_a !== vh[2]) begin
        n_err++;
        $display("FAIL stream_valid cycle %0d got %b exp %b", i, vout_a, vh[2]);
      end
      if (vout_a === 1'b1) begin
        n_vec++;
        if (q_a.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra cycle %0d got dout %h, exp no output", i, dout_a);
        end else begin
          e = q_a.pop_front();
          if ({dout_a, sat_a} !== e[16:0]) begin
            n_err++;
            $display("FAIL stream din=%h got %h/%b exp %h/%b", e[48:17], dout_a, sat_a, e[16:1], e[0]);
          end
        end
      end
      v = (i < 8) || ((i < 16) && ((i % 2) == 0));
      if (v) begin
        vec = STR_TBL[j % NSTR];
        j++;
        din_a = vec[48:17];
        q_a.push_back(vec);
      end else begin
        din_a = 32'h7F800000;
      end
      valid_a = v;
      vh = {vh[1:0], valid_a};
    end
    valid_a = 1'b0;
    n_vec++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain got %0d pending exp 0", q_a.size());
    end
  endtask

  // Reset while one sample sits on the output and two more are in S1/S2.
  task automatic test_reset_in_flight();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        n_vec++;
        if ({vout_a, dout_a, sat_a} !== {1'b1, 16'h7FFF, 1'b1}) begin
          n_err++;
          $display("FAIL rst_pre got v/d/s=%b/%h/%b exp 1/7fff/1", vout_a, dout_a, sat_a);
        end
      end
      case (i)
        0: begin din_a = 32'h7F800000; valid_a = 1'b1; end
        1: begin din_a = 32'h42C80000; valid_a = 1'b1; end
        2: begin din_a = 32'hC2C80000; valid_a = 1'b1; end
        default: begin din_a = 32'h0; valid_a = 1'b0; end
      endcase
    end
    #2 rstn = 1'b0;
    q_a.delete();
    #1;
    n_vec++;
    if ({vout_a, dout_a, sat_a} !== 18'd0) begin
      n_err++;
      $display("FAIL rst_async got v/d/s=%b/%h/%b exp 0/0000/0", vout_a, dout_a, sat_a);
    end
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({vout_a, dout_a, sat_a} !== 18'd0) begin
        n_err++;
        $display("FAIL rst_hold got v/d/s=%b/%h/%b exp 0/0000/0", vout_a, dout_a, sat_a);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (vout_a !== (i == 3)) begin
        n_err++;
        $display("FAIL rst_after_valid cycle %0d got %b exp %b", i, vout_a, (i == 3));
      end
      if (i == 3) begin
        n_vec++;
        if ({dout_a, sat_a} !== {16'h0003, 1'b0}) begin
          n_err++;
          $display("FAIL rst_after_data got %h/%b exp 0003/0", dout_a, sat_a);
        end
      end
      if (i == 0) begin
        din_a = 32'h40400000;
        valid_a = 1'b1;
      end else begin
        din_a = 32'h0;
        valid_a = 1'b0;
      end
    end
  endtask

  initial begin
    rstn    = 1'b1;
    din_a   = 32'h0;
    din_b   = 32'h0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    #1 rstn = 1'b0;
    test_reset();
    test_class_vectors();
    test_frac();
    test_back_to_back();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp32_to_fix.md
# fp32_to_fix

Pipelined converter from IEEE-754 single precision to signed two's-complement fixed point. It sits at the output end of the fp32 wavelet datapath and turns adder and filter results back into fixed-point samples for the DAC, memory or host interfaces. It is the decode direction matching the fp32 encode front end. It uses the same conventions as the fp32 arithmetic blocks: `valid_in`/`valid_out` qualified stream, no backpressure, one sample per clock, subnormals flushed to zero.

## Interface
Parameters:
- OUT_W, 16, output word width; legal range 8..32.
- FRAC_W, 0, fractional bits of the output; legal range 0..OUT_W-1. Output value = integer(dout) / 2^FRAC_W.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  32  fp32 input: sign [31], exponent [30:23], mantissa [22:0].
- valid_in  in  1  din qualifier.
- dout  out  OUT_W  signed fixed-point result.
- valid_out  out  1  dout qualifier.
- sat_flag  out  1  result was clamped, or input was NaN/Inf; meaningful only when valid_out=1.

## Operation
- Input classes:
  - exp==0 (zero or subnormal) -> 0, sat_flag=0.
  - exp==255 with mantissa==0 (±Inf) -> MAX or MIN by sign, sat_flag=1.
  - exp==255 with mantissa!=0 (NaN) -> 0, sat_flag=1.
- Normal numbers:
  - M = {1, mantissa} (24 bits); k = exp - 127 + FRAC_W, signed, 10 bits.
  - Magnitude = M·2^(k-23).
  - k ≥ 23: left shift.
  - k < 23: right shift by 23-k. Round to nearest, ties away from zero, using the bit just below the LSB.
  - k < -1: magnitude rounds to 0.
- Saturation:
  - MAX = 2^(OUT_W-1)-1; MIN = -2^(OUT_W-1).
  - Positive magnitude > MAX -> MAX, sat_flag=1.
  - Negative magnitude > 2^(OUT_W-1) -> MIN, sat_flag=1.
  - Negative magnitude == 2^(OUT_W-1) -> MIN, sat_flag=0.
  - Detect overflow early when k ≥ OUT_W so the shifter never needs more than OUT_W+1 result bits.
- Negative zero, or a negative value that rounds to 0, -> 0, with no sign artefact.

## Timing
- Latency: exactly 3 cycles, from valid_in sampled high to valid_out high with the matching dout. Throughput is 1 per cycle and there are no bubbles.
- Pipeline stages:
  - S1: register the class, sign, M, and k.
  - S2: shift, round, and overflow detection; register a magnitude of OUT_W+1 bits plus the ovf flag.
  - S3: negate, saturate, and register dout and sat_flag.
- The valid bit travels with the data. Data registers advance every cycle regardless of valid.
  - dout and sat_flag are don't-care while valid_out=0.
  - Benches compare outputs only on valid_out.
- Reset:
  - dout=0, valid_out=0, sat_flag=0, and all stage valid bits cleared. This takes effect asynchronously on rstn falling.
  - Samples in flight are discarded. No valid_out is produced for any input accepted before reset.
  - The first output after release comes 3 cycles after the first valid_in sampled with rstn high.
- valid_in toggling every cycle must produce valid_out toggling identically, delayed by 3 cycles.

## Structure
- Shared package `fp32_pkg` holds:
  - FP32_BIAS=127, FP32_EXP_W=8, FP32_MAN_W=23, FP32_EXP_MAX=8'hFF.
  - Class encoding: ZERO, NORM, INF, NAN.
- Sub-module `fp32_unpack` is combinational: din -> sign, exp, M with hidden bit, and class. It is reusable by the fp32 adder and multiplier front ends.
- The top level holds S1–S3 and the valid pipeline.

## Test plan
All cases use OUT_W=16, FRAC_W=0 unless noted.
- Rounding:
  - 0x3F000000 (0.5) -> 0x0001.
  - 0x3EFFFFFF -> 0x0000.
  - 0x3FC00000 (1.5) -> 0x0002.
  - 0xBFC00000 (-1.5) -> 0xFFFE.
  - 0x40200000 (2.5) -> 0x0003.
  - All of these with sat_flag=0.
- Saturation boundaries:
  - 0x46FFFE00 (32767) -> 0x7FFF, sat 0.
  - 0x47000000 (32768) -> 0x7FFF, sat 1.
  - 0xC7000000 (-32768) -> 0x8000, sat 0.
  - 0xC7000100 (-32769) -> 0x8000, sat 1.
  - 0x4F800000 (2^32) -> 0x7FFF, sat 1.
- Specials:
  - 0x7F800000 -> 0x7FFF, sat 1.
  - 0xFF800000 -> 0x8000, sat 1.
  - 0x7FC00000 -> 0x0000, sat 1.
  - 0x00400000 (subnormal) -> 0x0000, sat 0.
  - 0x80000000 -> 0x0000, sat 0.
- Fractional format, FRAC_W=8:
  - 0x3F800000 (1.0) -> 0x0100.
  - 0x3B800000 (2^-8) -> 0x0001.
  - 0xBB000000 (-2^-9) -> 0xFFFF, because ties round away from zero.
- Stream and reset:
  - Drive 8 back-to-back valid samples, then an alternating valid pattern. valid_out must mirror the valid_in pattern 3 cycles later, with values in order.
  - Pull rstn low with 2 samples in flight. valid_out, dout and sat_flag drop to 0 immediately, and those 2 samples never appear.
